ll_req_arbiter: RTL and testbench

//  Shares the single linked-list request/response interface controller among N_CLIENTS requesters.

---
 rtl/ll_pkg.sv | 35 +++
 rtl/ll_rr_arbiter.sv | 31 +++
 rtl/ll_req_arbiter.sv | 117 +++++++++++
 tb/tb_ll_req_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ll_pkg.sv
// Shared linked-list interface types: request/response opcodes, field widths and bundled structs.
package ll_pkg;

  localparam int PTR_WD     = 8;
  localparam int WR_DATA_WD = 8;

  typedef enum logic [2:0] {
    REQ_NOP,
    READ_NODE,
    WRITE_NODE,
    PUSH_HEAD,
    PUSH_TAIL,
    POP_HEAD
  } t_req_types;

  typedef enum logic [1:0] {
    RESP_NOP,
    RD_NODE_DATA,
    WR_DONE,
    ERROR
  } t_resp_types;

  typedef struct packed {
    t_req_types            rtype;
    logic [PTR_WD-1:0]     pos;
    logic [WR_DATA_WD-1:0] data;
  } t_ll_req;

  typedef struct packed {
    t_resp_types           rtype;
    logic [WR_DATA_WD-1:0] data;
    logic                  data_vld;
  } t_ll_resp;

endpackage

// File: rtl/ll_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module ll_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_oh,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  int j;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!gnt_any && req[j]) begin
        gnt_any   = 1'b1;
        gnt_oh[j] = 1'b1;
        gnt_idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/ll_req_arbiter.sv
// Round-robin share of the ll request/response controller among N_CLIENTS, one transaction in flight.
// Optional per-client grant counters: define LL_ARB_GRANT_CNT_EN.
module ll_req_arbiter
  import ll_pkg::*;
#(
  parameter int N_CLIENTS = 4,
  parameter int CNT_WD    = 16
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic        [N_CLIENTS-1:0]           cl_req_vld,
  input  t_req_types  [N_CLIENTS-1:0]           cl_req_type,
  input  logic        [N_CLIENTS-1:0][PTR_WD-1:0]     cl_req_pos,
  input  logic        [N_CLIENTS-1:0][WR_DATA_WD-1:0] cl_req_data,
  output logic        [N_CLIENTS-1:0]           cl_req_rdy,
  output logic        [N_CLIENTS-1:0]           cl_resp_vld,
  output t_resp_types                           cl_resp_type,
  output logic        [WR_DATA_WD-1:0]          cl_resp_data,
  output logic                                  cl_resp_data_vld,
  input  logic        [N_CLIENTS-1:0]           cl_resp_taken,
  output logic                                  dn_req_vld,
  output t_req_types                            dn_req_type,
  output logic        [PTR_WD-1:0]              dn_req_pos,
  output logic        [WR_DATA_WD-1:0]          dn_req_data,
  input  logic                                  dn_intf_ready,
  input  logic                                  dn_resp_vld,
  input  t_resp_types                           dn_resp_type,
  input  logic        [WR_DATA_WD-1:0]          dn_resp_data,
  input  logic                                  dn_resp_data_vld,
  output logic                                  dn_resp_taken,
  output logic        [N_CLIENTS-1:0][CNT_WD-1:0] grant_cnt
);

  localparam int IW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

  typedef enum logic [1:0] {ARB, ISSUE, WAIT_RESP, RETURN} t_arb_state;

  t_arb_state           state;
  logic [IW-1:0]        rr_ptr, owner, gnt_idx;
  logic [N_CLIENTS-1:0] gnt_oh;
  logic                 gnt_any, grant;
  t_ll_req              req_q;
  t_ll_resp             resp_q;

  ll_rr_arbiter #(.N(N_CLIENTS), .IW(IW)) u_rr (
    .req     (cl_req_vld),
    .ptr     (rr_ptr),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // Strobes are combinational; gating with reset_n keeps every output quiet while reset is held.
  assign grant         = reset_n && (state == ARB) && gnt_any;
  assign cl_req_rdy    = grant ? gnt_oh : '0;
  assign dn_resp_taken = reset_n && (state == WAIT_RESP) && dn_resp_vld;

  assign dn_req_type      = req_q.rtype;
  assign dn_req_pos       = req_q.pos;
  assign dn_req_data      = req_q.data;
  assign cl_resp_type     = resp_q.rtype;
  assign cl_resp_data     = resp_q.data;
  assign cl_resp_data_vld = resp_q.data_vld;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ARB;
      rr_ptr      <= '0;
      owner       <= '0;
      req_q       <= '0;
      resp_q      <= '0;
      dn_req_vld  <= 1'b0;
      cl_resp_vld <= '0;
    end else begin
      case (state)
        ARB: if (grant) begin
          owner      <= gnt_idx;
          req_q      <= '{rtype: cl_req_type[gnt_idx], pos: cl_req_pos[gnt_idx],
                          data: cl_req_data[gnt_idx]};
          rr_ptr     <= (gnt_idx == IW'(N_CLIENTS-1)) ? '0 : gnt_idx + 1'b1;
          dn_req_vld <= 1'b1;
          state      <= ISSUE;
        end
        ISSUE: if (dn_intf_ready) begin
          dn_req_vld <= 1'b0;
          state      <= WAIT_RESP;
        end
        WAIT_RESP: if (dn_resp_vld) begin
          resp_q      <= '{rtype: dn_resp_type, data: dn_resp_data, data_vld: dn_resp_data_vld};
          cl_resp_vld <= N_CLIENTS'(1) << owner;
          state       <= RETURN;
        end
        RETURN: if (cl_resp_taken[owner]) begin
          cl_resp_vld <= '0;
          state       <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end

`ifdef LL_ARB_GRANT_CNT_EN
  logic [N_CLIENTS-1:0][CNT_WD-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n)
      cnt_q <= '0;
    else if (grant && (cnt_q[gnt_idx] != '1))
      cnt_q[gnt_idx] <= cnt_q[gnt_idx] + 1'b1;
  end

  assign grant_cnt = cnt_q;
`else
  assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_ll_req_arbiter.sv
// Scoreboard bench for ll_req_arbiter: a bench-side downstream controller and round-robin model.
module tb_ll_req_arbiter;
  import ll_pkg::*;

  localparam int N      = 4;
  localparam int CNT_WD = 2;
  localparam int CNT_MAX = (1 << CNT_WD) - 1;

  logic                          clk = 1'b0;
  logic                          reset_n;
  logic        [N-1:0]           cl_req_vld;
  t_req_types  [N-1:0]           cl_req_type;
  logic        [N-1:0][PTR_WD-1:0]     cl_req_pos;
  logic        [N-1:0][WR_DATA_WD-1:0] cl_req_data;
  logic        [N-1:0]           cl_req_rdy;
  logic        [N-1:0]           cl_resp_vld;
  t_resp_types                   cl_resp_type;
  logic        [WR_DATA_WD-1:0]  cl_resp_data;
  logic                          cl_resp_data_vld;
  logic        [N-1:0]           cl_resp_taken;
  logic                          dn_req_vld;
  t_req_types                    dn_req_type;
  logic        [PTR_WD-1:0]      dn_req_pos;
  logic        [WR_DATA_WD-1:0]  dn_req_data;
  logic                          dn_intf_ready;
  logic                          dn_resp_vld;
  t_resp_types                   dn_resp_type;
  logic        [WR_DATA_WD-1:0]  dn_resp_data;
  logic                          dn_resp_data_vld;
  logic                          dn_resp_taken;
  logic        [N-1:0][CNT_WD-1:0] grant_cnt;

  ll_req_arbiter #(.N_CLIENTS(N), .CNT_WD(CNT_WD)) dut (
    .clk(clk), .reset_n(reset_n),
    .cl_req_vld(cl_req_vld), .cl_req_type(cl_req_type), .cl_req_pos(cl_req_pos),
    .cl_req_data(cl_req_data), .cl_req_rdy(cl_req_rdy),
    .cl_resp_vld(cl_resp_vld), .cl_resp_type(cl_resp_type), .cl_resp_data(cl_resp_data),
    .cl_resp_data_vld(cl_resp_data_vld), .cl_resp_taken(cl_resp_taken),
    .dn_req_vld(dn_req_vld), .dn_req_type(dn_req_type), .dn_req_pos(dn_req_pos),
    .dn_req_data(dn_req_data), .dn_intf_ready(dn_intf_ready),
    .dn_resp_vld(dn_resp_vld), .dn_resp_type(dn_resp_type), .dn_resp_data(dn_resp_data),
    .dn_resp_data_vld(dn_resp_data_vld), .dn_resp_taken(dn_resp_taken),
    .grant_cnt(grant_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_rr = 0;
  int m_cnt [N];

  t_ll_req  req_sb  [$];
  t_ll_resp resp_sb [$];
  int       gnt_sb  [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_grant(input logic [N-1:0] m);
    for (int i = 0; i < N; i++) begin
      int j;
      j = (m_rr + i) % N;
      if (m[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [31:0] oh(input int g);
    logic [31:0] v;
    v = 32'd1 << g;
    return v;
  endfunction

  task automatic drive_req(input logic [N-1:0] mask, input t_req_types ty, input int base);
    cl_req_vld = mask;
    for (int i = 0; i < N; i++) begin
      cl_req_type[i] = ty;
      cl_req_pos[i]  = PTR_WD'(base + i);
      cl_req_data[i] = WR_DATA_WD'(base ^ (i * 17));
    end
  endtask

  // One full transaction: grant, downstream issue with back-pressure, response, client return.
  task automatic txn(input logic [N-1:0] mask, input t_req_types ty, input int base,
                     input int rdy_dly, input int resp_dly, input t_resp_types rty,
                     input logic [7:0] rdata, input logic rdv, input int hold);
    int g;
    t_ll_req  er;
    t_ll_resp es;
    @(negedge clk); drive_req(mask, ty, base); #1;
    g = exp_grant(mask);
    chk("rdy_grant", 32'(cl_req_rdy), oh(g));
    req_sb.push_back('{rtype: ty, pos: PTR_WD'(base + g), data: WR_DATA_WD'(base ^ (g * 17))});
    gnt_sb.push_back(g);
    m_rr = (g + 1) % N;
`ifdef LL_ARB_GRANT_CNT_EN
    if (m_cnt[g] < CNT_MAX) m_cnt[g]++;
`endif
    @(negedge clk); #1;
    chk("grant_cnt", 32'(grant_cnt[g]), 32'(m_cnt[g]));
    for (int k = 0; k < rdy_dly; k++) begin
      chk("issue_vld", 32'(dn_req_vld), 1);
      chk("no_regrant", 32'(cl_req_rdy), 0);
      chk("stable_pos", 32'(dn_req_pos), 32'(req_sb[0].pos));
      chk("stable_data", 32'(dn_req_data), 32'(req_sb[0].data));
      @(negedge clk); #1;
    end
    dn_intf_ready = 1'b1; #1;
    chk("dn_vld", 32'(dn_req_vld), 1);
    er = req_sb.pop_front();
    chk("dn_type", 32'(dn_req_type), 32'(er.rtype));
    chk("dn_pos", 32'(dn_req_pos), 32'(er.pos));
    chk("dn_data", 32'(dn_req_data), 32'(er.data));
    @(negedge clk); dn_intf_ready = 1'b0; #1;
    chk("dn_vld_drop", 32'(dn_req_vld), 0);
    chk("rdy_wait", 32'(cl_req_rdy), 0);
    for (int k = 0; k < resp_dly; k++) begin
      chk("taken_idle", 32'(dn_resp_taken), 0);
      @(negedge clk); #1;
    end
    dn_resp_vld = 1'b1; dn_resp_type = rty; dn_resp_data = rdata; dn_resp_data_vld = rdv;
    resp_sb.push_back('{rtype: rty, data: rdata, data_vld: rdv});
    #1 chk("taken", 32'(dn_resp_taken), 1);
    @(negedge clk); dn_resp_vld = 1'b0; #1;
    chk("taken_pulse", 32'(dn_resp_taken), 0);
    g  = gnt_sb.pop_front();
    es = resp_sb.pop_front();
    chk("resp_type", 32'(cl_resp_type), 32'(es.rtype));
    chk("resp_data", 32'(cl_resp_data), 32'(es.data));
    chk("resp_dvld", 32'(cl_resp_data_vld), 32'(es.data_vld));
    for (int k = 0; k < hold; k++) begin
      cl_resp_taken = ~N'(oh(g)); #1;
      chk("resp_hold", 32'(cl_resp_vld), oh(g));
      chk("rdy_ret", 32'(cl_req_rdy), 0);
      @(negedge clk); #1;
    end
    cl_resp_taken = N'(oh(g)); #1;
    chk("resp_vld", 32'(cl_resp_vld), oh(g));
    chk("rdy_ret", 32'(cl_req_rdy), 0);
    @(negedge clk); #1;
    chk("resp_clr", 32'(cl_resp_vld), 0);
    cl_resp_taken = '0;
    cl_req_vld    = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    reset_n = 1'b0; cl_resp_taken = '0; dn_intf_ready = 1'b0;
    dn_resp_vld = 1'b0; dn_resp_type = RESP_NOP; dn_resp_data = '0; dn_resp_data_vld = 1'b0;
    drive_req('0, REQ_NOP, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_dn_vld", 32'(dn_req_vld), 0);
    chk("rst_resp_vld", 32'(cl_resp_vld), 0);
    chk("rst_cnt", 32'(grant_cnt), 0);
    reset_n = 1'b1;

    txn(4'b0001, READ_NODE, 3, 0, 2, RD_NODE_DATA, 8'h11, 1'b1, 0);

    // stray downstream response while idle must be ignored
    @(negedge clk); dn_resp_vld = 1'b1; dn_resp_type = ERROR; #1;
    chk("stray_taken", 32'(dn_resp_taken), 0);
    @(negedge clk); dn_resp_vld = 1'b0; #1;
    chk("stray_resp", 32'(cl_resp_vld), 0);

    for (int t = 0; t < 5; t++)
      txn(4'b1111, WRITE_NODE, 16 + t * 4, t % 2, 1, WR_DONE, 8'h00, 1'b0, 1);
    txn(4'b0110, PUSH_HEAD, 40, 5, 0, WR_DONE, 8'h00, 1'b0, 0);
    txn(4'b1000, READ_NODE, 50, 1, 3, RD_NODE_DATA, 8'hA5, 1'b1, 4);
    txn(4'b0101, POP_HEAD, 60, 0, 0, ERROR, 8'h3C, 1'b0, 2);

    // reset while waiting for the response
    @(negedge clk); drive_req(4'b1111, READ_NODE, 70); #1;
    chk("rst_pre_grant", 32'(cl_req_rdy), oh(exp_grant(4'b1111)));
    @(negedge clk); dn_intf_ready = 1'b1;
    @(negedge clk); dn_intf_ready = 1'b0; reset_n = 1'b0;
    @(negedge clk); #1;
    chk("rst_dn_vld", 32'(dn_req_vld), 0);
    chk("rst_rdy", 32'(cl_req_rdy), 0);
    chk("rst_resp", 32'(cl_resp_vld), 0);
    chk("rst_taken", 32'(dn_resp_taken), 0);
    chk("rst_pos", 32'(dn_req_pos), 0);
    chk("rst_cnt", 32'(grant_cnt), 0);
    reset_n = 1'b1; cl_req_vld = '0;
    m_rr = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    txn(4'b1111, READ_NODE, 80, 0, 0, RD_NODE_DATA, 8'h5A, 1'b1, 0);

    for (int t = 0; t < 5; t++)
      txn(4'b0010, WRITE_NODE, 90 + t, 0, 0, WR_DONE, 8'h00, 1'b0, 0);
    @(negedge clk); #1;
    for (int i = 0; i < N; i++)
      chk("final_cnt", 32'(grant_cnt[i]), 32'(m_cnt[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
